// File: rtl/fp_vector_adder_arbiter_if.sv
// Bus bundle between the requesters, the shared vector adder and the arbiter.
// The arbiter takes the slave modport; the requester/adder side takes master.
interface fp_vector_adder_arbiter_if #(
    parameter int WIDTH      = 32,
    parameter int NUM_INPUTS = 5,
    parameter int NUM_REQ    = 3
);
    localparam int VW = WIDTH * NUM_INPUTS;

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*VW-1:0] req_a;
    logic [NUM_REQ*VW-1:0] req_b;
    logic [NUM_REQ-1:0]    req_grant;
    logic [VW-1:0]         add_a;
    logic [VW-1:0]         add_b;
    logic                  add_ready;
    logic [VW-1:0]         add_o;
    logic                  add_valid;
    logic [VW-1:0]         res_o;
    logic [NUM_REQ-1:0]    res_valid;
    logic                  err;

    modport master (
        output req_valid, req_a, req_b, add_o, add_valid,
        input  req_grant, add_a, add_b, add_ready, res_o, res_valid, err
    );

    modport slave (
        input  req_valid, req_a, req_b, add_o, add_valid,
        output req_grant, add_a, add_b, add_ready, res_o, res_valid, err
    );
endinterface

// File: rtl/fp_vector_adder_arbiter.sv
// Round-robin sharing of one pipelined vector adder among NUM_REQ requesters;
// an in-order tag FIFO routes each returning result to the requester that issued it.
module fp_vector_adder_arbiter #(
    parameter int WIDTH      = 32,
    parameter int NUM_INPUTS = 5,
    parameter int NUM_REQ    = 3,
    parameter int LATENCY    = 11
) (
    input  logic                      clk,
    input  logic                      rst,
    fp_vector_adder_arbiter_if.slave  bus
);
    localparam int VW    = WIDTH * NUM_INPUTS;
    localparam int DEPTH = LATENCY + 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int IDX_W = ID_W + 1;

    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic               add_ready_q, add_ready_d;
    logic [VW-1:0]      add_a_q, add_a_d;
    logic [VW-1:0]      add_b_q, add_b_d;
    logic [VW-1:0]      res_o_q, res_o_d;
    logic [NUM_REQ-1:0] res_valid_q, res_valid_d;
    logic               err_q, err_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ID_W-1:0]    fifo_q [DEPTH];

    logic               grant_any;
    logic [ID_W-1:0]    grant_id;
    logic [IDX_W-1:0]   scan_idx;
    logic [NUM_REQ-1:0] grant;
    logic               fifo_empty;
    logic               fifo_full;
    logic               pop_valid;
    logic               bypass;
    logic               spurious;
    logic               overflow;
    logic               do_write;
    logic               do_read;
    logic [ID_W-1:0]    pop_tag;

    // Grants are suppressed while reset is held so nothing is accepted that would be lost.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        scan_idx  = '0;
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                scan_idx = {1'b0, rr_ptr_q} + IDX_W'(i);
                if (scan_idx >= IDX_W'(NUM_REQ)) begin
                    scan_idx = scan_idx - IDX_W'(NUM_REQ);
                end
                if (!grant_any && bus.req_valid[scan_idx[ID_W-1:0]]) begin
                    grant_any = 1'b1;
                    grant_id  = scan_idx[ID_W-1:0];
                end
            end
        end
        grant = grant_any ? (NUM_REQ'(1) << grant_id) : '0;
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        add_ready_d = grant_any;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        if (grant_any) begin
            rr_ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            add_a_d  = bus.req_a[grant_id*VW +: VW];
            add_b_d  = bus.req_b[grant_id*VW +: VW];
        end
    end

    // A result arriving on an empty FIFO in the same cycle as a push takes the
    // pushed tag directly; without a push it is a protocol error and is ignored.
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CNT_W'(DEPTH));
        pop_valid  = bus.add_valid && (!fifo_empty || grant_any);
        bypass     = bus.add_valid && fifo_empty && grant_any;
        spurious   = bus.add_valid && fifo_empty && !grant_any;
        overflow   = grant_any && fifo_full && !bus.add_valid;
        do_write   = grant_any && !overflow && !bypass;
        do_read    = pop_valid && !bypass;
        pop_tag    = fifo_empty ? grant_id : fifo_q[rd_ptr_q];

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_write) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_read) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (do_write && !do_read) begin
            count_d = count_q + 1'b1;
        end else if (!do_write && do_read) begin
            count_d = count_q - 1'b1;
        end

        res_o_d     = res_o_q;
        res_valid_d = '0;
        if (pop_valid) begin
            res_o_d     = bus.add_o;
            res_valid_d = NUM_REQ'(1) << pop_tag;
        end
        err_d = err_q || spurious || overflow;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            add_ready_q <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            res_o_q     <= '0;
            res_valid_q <= '0;
            err_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            add_ready_q <= add_ready_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            res_o_q     <= res_o_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Tag storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_write) begin
            fifo_q[wr_ptr_q] <= grant_id;
        end
    end

    assign bus.req_grant = grant;
    assign bus.add_a     = add_a_q;
    assign bus.add_b     = add_b_q;
    assign bus.add_ready = add_ready_q;
    assign bus.res_o     = res_o_q;
    assign bus.res_valid = res_valid_q;
    assign bus.err       = err_q;
endmodule

// File: doc/fp_vector_adder_arbiter.md
Name: fp_vector_adder_arbiter

Overview:
- Shares one fp_vector_adder (NUM_INPUTS lanes, fixed pipeline latency, in-order results) between NUM_REQ requesters.
- Uses round-robin arbitration.
- Records each issued operation's requester ID in an in-order tag FIFO. Each returning result is routed back to its requester by that ID.
- Sits between the LCMV compute stages and the single shared vector adder instance.

Parameters:
- WIDTH, 32, float word width
- NUM_INPUTS, 5, lanes per vector
- NUM_REQ, 3, number of requesters (>=2)
- LATENCY, 11, adder latency from add_ready to add_valid; sets tag FIFO depth to LATENCY+1

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  NUM_REQ  per-requester operation pending
- req_a  in  NUM_REQ*WIDTH*NUM_INPUTS  operand A vectors, requester r at slice r
- req_b  in  NUM_REQ*WIDTH*NUM_INPUTS  operand B vectors
- req_grant  out  NUM_REQ  one-hot, combinational; operation accepted this cycle
- add_a  out  WIDTH*NUM_INPUTS  registered operand A to adder
- add_b  out  WIDTH*NUM_INPUTS  registered operand B to adder
- add_ready  out  1  registered issue strobe to adder
- add_o  in  WIDTH*NUM_INPUTS  adder result
- add_valid  in  1  adder result valid
- res_o  out  WIDTH*NUM_INPUTS  registered result, broadcast to all requesters
- res_valid  out  NUM_REQ  registered one-hot; result belongs to requester r
- err  out  1  sticky protocol error

Behaviour:
- Reset (asynchronous) clears the following to 0: req_grant, add_ready, add_a, add_b, res_o, res_valid, err, RR pointer, FIFO pointers, FIFO count.
- Handshake: a requester holds req_valid and its operands stable until it sees req_grant. The transfer occurs in the cycle where req_valid[r] and req_grant[r] are both 1. A requester may drop req_valid before it is granted (no grant results).
- Arbitration, combinational:
  - Search from rr_ptr upward, wrapping modulo NUM_REQ.
  - The first r with req_valid[r]=1 is granted.
  - At most one grant per cycle. No grant if req_valid==0.
- Pointer update: on a grant to r, rr_ptr <= (r+1) mod NUM_REQ. Otherwise rr_ptr holds.
- Issue: on the clock edge after a grant:
  - add_ready <= 1.
  - add_a/add_b <= the granted requester's slices.
  - ID r is pushed into the tag FIFO.
  - With no grant, add_ready <= 0 and add_a/add_b hold.
- Throughput: one issue per cycle. No stalls, because the adder is fully pipelined.
- Return: when add_valid=1, pop tag t:
  - Next cycle: res_o <= add_o, res_valid <= one-hot(t).
  - Otherwise res_valid <= 0 and res_o holds.
- End-to-end latency: grant cycle G -> add_ready at G+1 -> add_valid at G+1+LATENCY -> res_valid at G+2+LATENCY.
- Tag FIFO:
  - Depth LATENCY+1, with circular wrap of the read and write pointers.
  - A push and a pop in the same cycle are both honoured and leave the count unchanged.
  - Occupancy never exceeds depth under a correct adder.
  - If a push arrives while full: set err and drop the push.
- Spurious result: add_valid with the FIFO empty and no push the same cycle:
  - err <= 1.
  - res_valid stays 0.
  - No pop.
- err is sticky until rst.
- The adder's own reset is driven from the same rst, so no stale add_valid appears after reset.
- A requester may be granted again while its earlier results are still in flight; results return strictly in issue order.

Test Plan:
- Single requester: r1 issues a=all lanes 0x3F800000, b=all lanes 0x40000000 (1.0+2.0), bench adder model LATENCY=11, grant at cycle 5 -> add_ready at 6; res_valid=3'b010 at cycle 18 with res_o all lanes 0x40400000.
- Fairness: all three req_valid held high for 9 cycles -> grant sequence 0,1,2,0,1,2,0,1,2; add_ready high for 9 consecutive cycles; res_valid sequence one-hot 0,1,2,... with no gaps.
- Pointer skip: only r0 and r2 valid, rr_ptr=1 -> grant r2, then r0, then r2; r1 is never granted.
- Full pipeline plus simultaneous push/pop: continuous requests for 40 cycles -> FIFO count settles at LATENCY+1 with push and pop in the same cycle; err stays 0; every result is tagged to the correct requester.
- Reset mid-flight: assert rst with 6 operations in flight -> all outputs 0 immediately; after release, no res_valid until a new grant; rr_ptr restarts at 0.
- Spurious add_valid with FIFO empty -> err=1, res_valid=0; err stays 1 until rst.
